// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the physical-memory port.
// The arbiter uses the slave view; the surrounding caches/memory use the master view.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              busy;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output busy
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  busy
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between icache and dcache.
// Latches the granted request and holds it on the memory side until pmem_resp.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant;
  logic w_grant_d;
  logic w_serving;

  assign w_i_req = bus.i_pmem_read;
  assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

  // On a tie the side that did not win last time is granted.
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          w_grant   = 1'b1;
          w_grant_d = ~r_last_grant;
        end else if (w_i_req || w_d_req) begin
          w_grant   = 1'b1;
          w_grant_d = w_d_req;
        end
        if (w_grant) begin
          w_next = w_grant_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A dcache read+write collision is treated as a write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant) begin
      r_last_grant <= w_grant_d;
      r_write      <= w_grant_d & bus.d_pmem_write;
      r_addr       <= w_grant_d ? bus.d_pmem_address : bus.i_pmem_address;
      r_wdata      <= w_grant_d ? bus.d_pmem_wdata : '0;
    end
  end

  assign w_serving = (r_state == SERVE_I) || (r_state == SERVE_D);

  assign bus.pmem_read    = w_serving & ~r_write;
  assign bus.pmem_write   = w_serving & r_write;
  assign bus.pmem_address = r_addr;
  assign bus.pmem_wdata   = r_wdata;
  assign bus.busy         = w_serving;

  assign bus.i_pmem_resp  = (r_state == SERVE_I) & bus.pmem_resp;
  assign bus.d_pmem_resp  = (r_state == SERVE_D) & bus.pmem_resp;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected grants are queued as requests are
// driven and popped when the memory side shows the corresponding transaction.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk;
  logic rst;

  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                side;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next granted transaction, checks it against the scoreboard head,
  // answers it after lat strobe cycles and checks the mandatory idle cycle.
  task automatic do_txn(input int lat, input logic [LINE_W-1:0] rd, input int exp_wait,
                        input bit keep, input bit chg);
    exp_t e;
    int   waited;
    bit   got;
    waited = 0;
    got    = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      waited++;
      if (bus.pmem_read || bus.pmem_write) got = 1;
    end
    if (!got) begin
      chk("strobe_timeout", 256'(0), 256'(1));
      return;
    end
    chk("grant_gap", 256'(waited), 256'(exp_wait));
    if (sb.size() == 0) begin
      chk("sb_empty", 256'(0), 256'(1));
      return;
    end
    e = sb.pop_front();
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      chk("pmem_address", 256'(bus.pmem_address), 256'(e.addr));
      chk("pmem_write", 256'(bus.pmem_write), 256'(e.wr));
      chk("pmem_read", 256'(bus.pmem_read), 256'(!e.wr));
      chk("busy", 256'(bus.busy), 256'(1));
      if (e.wr) chk("pmem_wdata", bus.pmem_wdata, e.wdata);
      if (c == lat) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rd;
        #1;
      end
      chk("i_pmem_resp", 256'(bus.i_pmem_resp), 256'((c == lat) && !e.side));
      chk("d_pmem_resp", 256'(bus.d_pmem_resp), 256'((c == lat) && e.side));
      if (c == lat) begin
        if (e.side) chk("d_pmem_rdata", bus.d_pmem_rdata, rd);
        else        chk("i_pmem_rdata", bus.i_pmem_rdata, rd);
      end
      if (chg && c == 1) bus.d_pmem_address = 32'hFFFF_FFE0;
    end
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
    if (!keep) begin
      if (e.side) begin
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
      end else begin
        bus.i_pmem_read = 1'b0;
      end
    end
    @(negedge clk);
    chk("idle_after_resp", 256'({bus.pmem_read, bus.pmem_write, bus.busy}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit got;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", 256'({bus.pmem_read, bus.pmem_write, bus.busy}), 256'(0));
    chk("rst_resps", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    chk("rst_address", 256'(bus.pmem_address), 256'(0));
    chk("rst_wdata", bus.pmem_wdata, 256'(0));

    // Tie right after reset: icache first, dcache next, icache re-request after.
    rst = 1'b1;
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_1000;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_3000;
    sb.push_back('{side: 1'b0, wr: 1'b0, addr: 32'h0000_1000, wdata: '0});
    sb.push_back('{side: 1'b1, wr: 1'b0, addr: 32'h0000_3000, wdata: '0});
    sb.push_back('{side: 1'b0, wr: 1'b0, addr: 32'h0000_1000, wdata: '0});
    do_txn(3, {8{32'h1111_0001}}, 2, 1'b1, 1'b0);
    do_txn(2, {8{32'h2222_0002}}, 1, 1'b0, 1'b0);
    do_txn(2, {8{32'h3333_0003}}, 1, 1'b0, 1'b0);

    // Icache fill, response after 5 cycles.
    @(posedge clk); #1;
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_0100;
    sb.push_back('{side: 1'b0, wr: 1'b0, addr: 32'h0000_0100, wdata: '0});
    do_txn(5, {8{32'hA5A5_5A5A}}, 2, 1'b0, 1'b0);

    // Dcache write-back.
    @(posedge clk); #1;
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_2040;
    bus.d_pmem_wdata   = {8{32'hDEADBEEF}};
    sb.push_back('{side: 1'b1, wr: 1'b1, addr: 32'h0000_2040, wdata: {8{32'hDEADBEEF}}});
    do_txn(3, {8{32'h0BAD_F00D}}, 2, 1'b0, 1'b0);

    // Dcache read whose address changes after the grant.
    @(posedge clk); #1;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_4000;
    sb.push_back('{side: 1'b1, wr: 1'b0, addr: 32'h0000_4000, wdata: '0});
    do_txn(4, {8{32'hCAFE_0004}}, 2, 1'b0, 1'b1);

    // Read and write together resolve to a write.
    @(posedge clk); #1;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 32'h0000_5000;
    bus.d_pmem_wdata   = {8{32'h1234_5678}};
    sb.push_back('{side: 1'b1, wr: 1'b1, addr: 32'h0000_5000, wdata: {8{32'h1234_5678}}});
    do_txn(3, {8{32'h0000_0005}}, 2, 1'b0, 1'b0);

    // Stray memory response while idle.
    @(posedge clk); #1;
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    chk("idle_resp_fwd", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    chk("idle_resp_strobe", 256'({bus.pmem_read, bus.pmem_write, bus.busy}), 256'(0));
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;

    // Asynchronous reset two cycles into an icache fill.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 32'h0000_6000;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.pmem_read) got = 1;
    end
    chk("rst_test_grant", 256'(got), 256'(1));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_strobes", 256'({bus.pmem_read, bus.pmem_write, bus.busy}), 256'(0));
    chk("async_rst_resps", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    chk("async_rst_address", 256'(bus.pmem_address), 256'(0));
    bus.i_pmem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    got = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write || bus.busy) got = 1;
    end
    chk("no_replay", 256'(got), 256'(0));
    chk("sb_drained", 256'(sb.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
